// File: rtl/rs_dec_pkg.sv
// Shared parameters, derived widths, serializer state and the frame<->symbol
// bit mapping used by both the serializer and the collector.
package rs_dec_pkg;

    localparam int unsigned PLANES_DEF = 3;
    localparam int unsigned BPP_DEF    = 2;
    localparam int unsigned N_SYM_DEF  = 54;
    localparam int unsigned K_SYM_DEF  = 34;

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } ser_state_t;

    function automatic int unsigned sym_w(input int unsigned planes, input int unsigned bpp);
        return planes * bpp;
    endfunction

    function automatic int unsigned din_w(input int unsigned planes, input int unsigned bpp,
                                          input int unsigned n_sym);
        return planes * bpp * n_sym;
    endfunction

    function automatic int unsigned dout_w(input int unsigned planes, input int unsigned bpp,
                                           input int unsigned k_sym);
        return planes * bpp * k_sym;
    endfunction

    // Symbol bit carrying plane p, sub-bit b (plane-interleaved, MSB first)
    function automatic int unsigned sym_bit(input int unsigned planes, input int unsigned bpp,
                                            input int unsigned p, input int unsigned b);
        return planes * bpp - 1 - (b * planes + p);
    endfunction

    // Frame bit of plane p, symbol s, sub-bit b for a frame of len symbols per plane
    function automatic int unsigned frame_bit(input int unsigned len, input int unsigned bpp,
                                              input int unsigned p, input int unsigned s,
                                              input int unsigned b);
        return p * len * bpp + s * bpp + b;
    endfunction

endpackage

// File: rtl/rs_sym_collector.sv
// Collects the first K_SYM decoded symbols of each codeword and re-packs them
// into a plane-major message frame with a one-cycle dout_valid pulse.
module rs_sym_collector
    import rs_dec_pkg::*;
#(
    parameter int unsigned PLANES = PLANES_DEF,
    parameter int unsigned BPP    = BPP_DEF,
    parameter int unsigned K_SYM  = K_SYM_DEF,
    localparam int unsigned SYM_W  = sym_w(PLANES, BPP),
    localparam int unsigned DOUT_W = dout_w(PLANES, BPP, K_SYM)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [SYM_W-1:0]  i_sym,
    input  logic              i_valid,
    input  logic              i_start,
    input  logic              i_fail,
    output logic [DOUT_W-1:0] o_dout,
    output logic              o_dout_valid,
    output logic              o_dout_fail
);

    localparam int unsigned IDX_W = (K_SYM > 1) ? $clog2(K_SYM) : 1;

    logic [SYM_W-1:0]  r_msg [K_SYM];
    logic [IDX_W-1:0]  r_idx;
    logic              r_active;
    logic              r_done;
    logic              r_fail;
    logic              w_wr;
    logic              w_last;
    logic [IDX_W-1:0]  w_widx;
    logic [DOUT_W-1:0] w_dout;

    // A start symbol always (re)opens a collection at index 0
    assign w_wr   = i_valid && (i_start || r_active);
    assign w_widx = i_start ? '0 : r_idx;
    assign w_last = w_wr && (w_widx == IDX_W'(K_SYM - 1));

    for (genvar k = 0; k < K_SYM; k++) begin : g_msg
        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                r_msg[k] <= '0;
            end else if (w_wr && (w_widx == IDX_W'(k))) begin
                r_msg[k] <= i_sym;
            end else if (r_done) begin
                r_msg[k] <= '0;
            end
        end
    end

    for (genvar s = 0; s < K_SYM; s++) begin : g_map_s
        for (genvar p = 0; p < PLANES; p++) begin : g_map_p
            for (genvar b = 0; b < BPP; b++) begin : g_map_b
                assign w_dout[frame_bit(K_SYM, BPP, p, s, b)] = r_msg[s][sym_bit(PLANES, BPP, p, b)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_idx        <= '0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            o_dout       <= '0;
            o_dout_valid <= 1'b0;
            o_dout_fail  <= 1'b0;
        end else begin
            r_done       <= w_last;
            o_dout_valid <= r_done;
            if (w_last) begin
                r_fail <= i_fail;
            end
            if (r_done) begin
                o_dout      <= w_dout;
                o_dout_fail <= r_fail;
            end
            if (w_wr) begin
                r_active <= !w_last;
                r_idx    <= w_widx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/rs_decoder_par.sv
// Parallel-frame wrapper around an external RS decoder core: serializes frames
// into symbols and re-packs decoded messages. Optional stats via RS_DEC_STATS_EN.
module rs_decoder_par
    import rs_dec_pkg::*;
#(
    parameter int unsigned PLANES = PLANES_DEF,
    parameter int unsigned BPP    = BPP_DEF,
    parameter int unsigned N_SYM  = N_SYM_DEF,
    parameter int unsigned K_SYM  = K_SYM_DEF,
    localparam int unsigned SYM_W  = sym_w(PLANES, BPP),
    localparam int unsigned DIN_W  = din_w(PLANES, BPP, N_SYM),
    localparam int unsigned DOUT_W = dout_w(PLANES, BPP, K_SYM)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [SYM_W-1:0]  dec_sym,
    output logic              dec_valid,
    output logic              dec_start,
    input  logic [SYM_W-1:0]  dec_out_sym,
    input  logic              dec_out_valid,
    input  logic              dec_out_start,
    input  logic              dec_fail,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_fail,
    output logic              overrun,
    output logic [15:0]       fail_cnt,
    output logic [15:0]       ovr_cnt
);

    localparam int unsigned CNT_W = $clog2(N_SYM);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic             w_capture;
    logic             w_last;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SYM_W-1:0] w_din_syms [N_SYM];
    logic [SYM_W-1:0] r_syms [N_SYM];

    for (genvar s = 0; s < N_SYM; s++) begin : g_sym_s
        for (genvar p = 0; p < PLANES; p++) begin : g_sym_p
            for (genvar b = 0; b < BPP; b++) begin : g_sym_b
                assign w_din_syms[s][sym_bit(PLANES, BPP, p, b)] = din[frame_bit(N_SYM, BPP, p, s, b)];
            end
        end
    end

    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (din_valid) begin
                    w_state_nxt = SERIAL;
                    w_capture   = 1'b1;
                end
            end
            SERIAL: begin
                if (r_cnt == CNT_W'(N_SYM - 1)) begin
                    w_state_nxt = IDLE;
                    w_last      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Symbol 0 leaves straight from din so it appears the cycle after capture
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_syms <= w_din_syms;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt     <= '0;
            dec_sym   <= '0;
            dec_valid <= 1'b0;
            dec_start <= 1'b0;
            din_ready <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            din_ready <= (w_state_nxt == IDLE);
            dec_valid <= (w_state_nxt == SERIAL);
            dec_start <= w_capture;
            overrun   <= din_valid && (r_state != IDLE);
            if (w_capture) begin
                r_cnt   <= '0;
                dec_sym <= w_din_syms[0];
            end else if (w_last) begin
                dec_sym <= '0;
            end else if (r_state == SERIAL) begin
                r_cnt   <= w_cnt_nxt;
                dec_sym <= r_syms[w_cnt_nxt];
            end
        end
    end

    rs_sym_collector #(
        .PLANES (PLANES),
        .BPP    (BPP),
        .K_SYM  (K_SYM)
    ) u_collector (
        .clk          (clk),
        .reset_b      (reset_b),
        .i_sym        (dec_out_sym),
        .i_valid      (dec_out_valid),
        .i_start      (dec_out_start),
        .i_fail       (dec_fail),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_dout_fail  (dout_fail)
    );

`ifdef RS_DEC_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            fail_cnt <= '0;
            ovr_cnt  <= '0;
        end else begin
            if (dout_valid && dout_fail && (fail_cnt != 16'hFFFF)) begin
                fail_cnt <= fail_cnt + 16'd1;
            end
            if (overrun && (ovr_cnt != 16'hFFFF)) begin
                ovr_cnt <= ovr_cnt + 16'd1;
            end
        end
    end
`else
    assign fail_cnt = '0;
    assign ovr_cnt  = '0;
`endif

endmodule
